pkt_verdict_gate: RTL and testbench
===================================

Name: pkt_verdict_gate

Overview:
- Store-and-forward gate directly downstream of the bloom-filter match stage on the 64-bit data / 8-bit ctrl packet bus.
- Buffers one complete packet while the matcher evaluates it, then takes the per-packet verdict:
  - clean packets are forwarded to the output queue;
  - matching packets are dropped.
- Maintains pass, drop and timeout counters for register readout.

Parameters:
- DEPTH, 256, packet buffer depth in 64-bit words (power of two)
- TIMEOUT, 64, cycles to wait for a verdict after the end word before forcing a decision
- FAIL_OPEN, 1, 1 = forward on timeout, 0 = drop on timeout

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  64  packet word
- in_ctrl  input  8  word control; nonzero = header or end word
- in_wr  input  1  word valid
- in_rdy  output  1  gate can accept a word this cycle
- verdict_valid  input  1  one-cycle pulse from the matcher at end of packet
- verdict_match  input  1  1 = packet matched a signature; sampled with verdict_valid
- out_data  output  64  forwarded word
- out_ctrl  output  8  forwarded control
- out_wr  output  1  output word valid
- out_rdy  input  1  downstream can accept
- pass_count  output  32  packets forwarded
- drop_count  output  32  packets dropped (match, oversize or timeout-drop)
- timeout_count  output  32  verdicts that timed out

Behaviour:
- Reset (async):
  - state IDLE; buffer pointers 0; verdict latch cleared;
  - in_rdy=0 while reset is asserted, 1 in IDLE afterwards;
  - out_wr=0, out_data=0, out_ctrl=0; all counters 0;
  - reset mid-packet discards buffer contents; no partial packet is ever emitted.
- Framing, same as the matcher:
  - START→HEADER on a word with ctrl≠0;
  - HEADER→PAYLOAD on ctrl=0;
  - PAYLOAD→end on the next ctrl≠0.
  - The end word is stored and forwarded.
- A word is accepted when in_wr && in_rdy. in_wr while in_rdy=0 is ignored and not stored.
- IDLE: in_rdy=1. The first accepted ctrl≠0 word is written to address 0 and the state goes to STORE. ctrl=0 words in IDLE are discarded.
- STORE: in_rdy=1; each accepted word is written at wr_ptr, then wr_ptr++.
  - Acceptance of the end word → WAIT_V, with timer=0.
  - Oversize: word count > DEPTH sets the oversize flag. Further words are consumed but not written until the end word, then the gate goes to DROP.
- WAIT_V: in_rdy=0; timer increments every cycle.
  - verdict_valid with match=0 → FWD.
  - verdict_valid with match=1 → DROP.
  - timer reaching TIMEOUT-1 with no verdict: timeout_count++, then FWD if FAIL_OPEN else DROP.
- Early verdict: verdict_valid while in STORE is latched and consumed on entry to WAIT_V, giving 1 cycle in WAIT_V.
- verdict_valid in IDLE, FWD or DROP is ignored.
- FWD: in_rdy=0; words are read in order from address 0 to wr_ptr-1.
  - Outputs are registered. The first out_wr rises the cycle after FWD entry.
  - out_data, out_ctrl and out_wr hold stable while out_rdy=0. A word transfers on out_wr && out_rdy.
  - On the last word's transfer: pass_count++, pointers cleared → IDLE.
- DROP: single cycle; drop_count++, pointers cleared → IDLE. out_wr is never asserted.
- Counters are 32-bit and wrap modulo 2^32.
- Throughput: one packet in flight. Minimum turnaround from end word to next in_rdy=1 is 3 cycles plus forward length.

Decomposition:
- Shared package nids_pkg holds:
  - state enum (IDLE, STORE, WAIT_V, FWD, DROP);
  - framing enum (START, HEADER, PAYLOAD), reused from the matcher stage;
  - DATA_W=64 and CTRL_W=8.
- One sub-module: pkt_buf_ram, a simple dual-port DEPTH×72 RAM with synchronous read, 1-cycle read latency. Its latency is absorbed by a one-entry output skid register in the gate.

Test Plan:
- Clean packet (2 header, 4 payload, 1 end words), verdict_match=0 two cycles after the end word → the 7 words appear on out_* in order, with identical data and ctrl; pass_count=1.
- Same packet with verdict_match=1 → out_wr stays 0 throughout; drop_count=1; in_rdy returns to 1 one cycle after DROP.
- Clean packet with out_rdy toggling 1,0,0,1,… → no word lost or duplicated; out_data is stable during each stall.
- No verdict, TIMEOUT=64 → timeout_count=1 at end-word+64 cycles:
  - FAIL_OPEN=1: packet forwarded, pass_count=1;
  - FAIL_OPEN=0: packet dropped, drop_count=1.
- DEPTH=256 with a 300-word packet and verdict_match=0 → nothing forwarded; drop_count=1; the following 7-word packet is forwarded intact.
- Reset asserted during FWD at word 3 → out_wr=0 immediately; counters 0; the next packet is forwarded correctly from word 0.

Source files
------------

// File: rtl/nids_pkg.sv
// Shared definitions for the NIDS packet path (matcher and verdict gate).
// Holds the bus widths, the verdict-gate state encoding, the framing
// states shared with the bloom-filter matcher, and a word-packing helper
// used when storing a data/ctrl pair in the packet buffer.
package nids_pkg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 8;
  localparam int WORD_W = DATA_W + CTRL_W;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    WAIT_V,
    FWD,
    DROP
  } gate_state_t;

  // Packet framing as seen by the matcher: a nonzero-ctrl word opens the
  // header, the first zero-ctrl word starts the payload, and the next
  // nonzero-ctrl word closes the packet.
  typedef enum logic [1:0] {
    START,
    HEADER,
    PAYLOAD
  } frame_t;

  function automatic logic [WORD_W-1:0] pack_word(input logic [CTRL_W-1:0] ctrl,
                                                   input logic [DATA_W-1:0] data);
    return {ctrl, data};
  endfunction

endpackage

// File: rtl/pkt_verdict_gate_if.sv
// Packet bus bundle around the verdict gate.
//   in_data/in_ctrl/in_wr/in_rdy         : ingress word stream
//   verdict_valid/verdict_match          : per-packet verdict from the matcher
//   out_data/out_ctrl/out_wr/out_rdy     : egress word stream
// modport slave  : the gate side
// modport master : the upstream/downstream environment side
interface pkt_verdict_gate_if;
  import nids_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_wr;
  logic              in_rdy;
  logic              verdict_valid;
  logic              verdict_match;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_wr;
  logic              out_rdy;

  modport slave (
    input  in_data, in_ctrl, in_wr, verdict_valid, verdict_match, out_rdy,
    output in_rdy, out_data, out_ctrl, out_wr
  );

  modport master (
    output in_data, in_ctrl, in_wr, verdict_valid, verdict_match, out_rdy,
    input  in_rdy, out_data, out_ctrl, out_wr
  );

endinterface

// File: rtl/pkt_buf_ram.sv
// Simple dual-port packet buffer: one write port, one read port, synchronous
// read with one cycle of latency. The read port samples rd_addr every cycle.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write word (ctrl:data)
//   rd_addr  : read address, sampled every clock
//   rd_data  : word at the rd_addr of the previous cycle
module pkt_buf_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 72
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pkt_verdict_gate.sv
// Store-and-forward verdict gate behind the bloom-filter matcher.
// Buffers one whole packet, waits for the matcher's verdict (or a timeout),
// then forwards the packet unchanged or discards it.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   bus            : packet bus (ingress stream, verdict, egress stream)
//   pass_count     : packets forwarded
//   drop_count     : packets dropped (match, oversize, timeout-drop)
//   timeout_count  : verdict waits that expired
module pkt_verdict_gate
  import nids_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int TIMEOUT   = 64,
  parameter bit FAIL_OPEN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  pkt_verdict_gate_if.slave   bus,
  output logic [31:0]         pass_count,
  output logic [31:0]         drop_count,
  output logic [31:0]         timeout_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;              // word counters reach DEPTH itself
  localparam int TW = $clog2(TIMEOUT) + 1;

  gate_state_t       state;
  frame_t            frame;
  logic [CW-1:0]     wr_ptr;
  logic [CW-1:0]     rd_ptr;
  logic [TW-1:0]     timer;
  logic              oversize;
  logic              vl_valid;
  logic              vl_match;
  logic              in_rdy_q;

  logic [DATA_W-1:0] out_data_p1;
  logic [CTRL_W-1:0] out_ctrl_p1;
  logic              out_wr_p1;

  logic              acc_p0;
  logic              ctrl_nz_p0;
  logic              full_p0;
  logic              ram_we_p0;
  logic [AW-1:0]     ram_rd_addr;
  logic [WORD_W-1:0] ram_rd_data;
  logic              load_p1;
  logic              v_hit;
  logic              v_match;

  assign acc_p0     = bus.in_wr && in_rdy_q;
  assign ctrl_nz_p0 = |bus.in_ctrl;
  assign full_p0    = (wr_ptr == CW'(DEPTH));

  // IDLE only stores the opening header word; STORE stores until the buffer
  // is full, after which words are swallowed up to the end word.
  assign ram_we_p0 = acc_p0 && (((state == IDLE) && ctrl_nz_p0) ||
                                ((state == STORE) && !full_p0));

  // The output register takes a new word whenever it is empty or its word
  // is leaving this cycle, and words remain in the buffer.
  assign load_p1 = (state == FWD) && (!out_wr_p1 || bus.out_rdy) && (rd_ptr != wr_ptr);

  // The RAM read is one cycle behind its address, so the address runs one
  // word ahead on every load: ram_rd_data always holds the word at rd_ptr.
  // Outside FWD rd_ptr is 0, so word 0 is already waiting on FWD entry.
  assign ram_rd_addr = load_p1 ? AW'(rd_ptr + 1'b1) : AW'(rd_ptr);

  // A verdict latched during STORE takes priority over the live strobe.
  assign v_hit   = vl_valid || bus.verdict_valid;
  assign v_match = vl_valid ? vl_match : bus.verdict_match;

  pkt_buf_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (ram_we_p0),
    .wr_addr (AW'(wr_ptr)),
    .wr_data (pack_word(bus.in_ctrl, bus.in_data)),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      frame         <= START;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      timer         <= '0;
      oversize      <= 1'b0;
      vl_valid      <= 1'b0;
      vl_match      <= 1'b0;
      in_rdy_q      <= 1'b0;
      out_data_p1   <= '0;
      out_ctrl_p1   <= '0;
      out_wr_p1     <= 1'b0;
      pass_count    <= '0;
      drop_count    <= '0;
      timeout_count <= '0;
    end else begin
      case (state)
        // ---- ingress: wait for a packet start ----
        IDLE: begin
          in_rdy_q <= 1'b1;
          vl_valid <= 1'b0;
          if (acc_p0 && ctrl_nz_p0) begin
            wr_ptr   <= CW'(1);
            frame    <= HEADER;
            oversize <= 1'b0;
            state    <= STORE;
          end
        end

        // ---- ingress: buffer the packet body ----
        STORE: begin
          if (bus.verdict_valid) begin
            vl_valid <= 1'b1;
            vl_match <= bus.verdict_match;
          end
          if (acc_p0) begin
            if (full_p0) begin
              oversize <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
            if ((frame == HEADER) && !ctrl_nz_p0) begin
              frame <= PAYLOAD;
            end else if ((frame == PAYLOAD) && ctrl_nz_p0) begin
              frame    <= START;
              in_rdy_q <= 1'b0;
              timer    <= '0;
              state    <= (full_p0 || oversize) ? DROP : WAIT_V;
            end
          end
        end

        // ---- verdict wait with timeout ----
        WAIT_V: begin
          timer <= timer + 1'b1;
          if (v_hit) begin
            vl_valid <= 1'b0;
            state    <= v_match ? DROP : FWD;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            timeout_count <= timeout_count + 32'd1;
            state         <= FAIL_OPEN ? FWD : DROP;
          end
        end

        // ---- egress: replay buffer through the output register ----
        FWD: begin
          if (load_p1) begin
            out_data_p1 <= ram_rd_data[DATA_W-1:0];
            out_ctrl_p1 <= ram_rd_data[WORD_W-1:DATA_W];
            out_wr_p1   <= 1'b1;
            rd_ptr      <= rd_ptr + 1'b1;
          end else if (out_wr_p1 && bus.out_rdy) begin
            out_wr_p1 <= 1'b0;
            if (rd_ptr == wr_ptr) begin
              pass_count <= pass_count + 32'd1;
              wr_ptr     <= '0;
              rd_ptr     <= '0;
              in_rdy_q   <= 1'b1;
              state      <= IDLE;
            end
          end
        end

        // ---- discard ----
        DROP: begin
          drop_count <= drop_count + 32'd1;
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          oversize   <= 1'b0;
          vl_valid   <= 1'b0;
          in_rdy_q   <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_rdy   = in_rdy_q;
  assign bus.out_data = out_data_p1;
  assign bus.out_ctrl = out_ctrl_p1;
  assign bus.out_wr   = out_wr_p1;

endmodule

// File: tb/tb_pkt_verdict_gate.sv
// Directed bench for pkt_verdict_gate. Two instances share the same
// stimulus: dut (FAIL_OPEN=1, scoreboarded) and dut0 (FAIL_OPEN=0, counters
// checked for the timeout-drop case). Expected egress words are queued as
// packets are driven and popped as transfers happen.
module tb_pkt_verdict_gate;

  logic clk;
  logic reset;

  pkt_verdict_gate_if b ();
  pkt_verdict_gate_if b0 ();

  logic [31:0] pass1, drop1, to1;
  logic [31:0] pass0, drop0, to0;

  assign b0.in_data       = b.in_data;
  assign b0.in_ctrl       = b.in_ctrl;
  assign b0.in_wr         = b.in_wr;
  assign b0.verdict_valid = b.verdict_valid;
  assign b0.verdict_match = b.verdict_match;
  assign b0.out_rdy       = b.out_rdy;

  pkt_verdict_gate #(.DEPTH(256), .TIMEOUT(64), .FAIL_OPEN(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (b),
    .pass_count    (pass1),
    .drop_count    (drop1),
    .timeout_count (to1)
  );

  pkt_verdict_gate #(.DEPTH(256), .TIMEOUT(64), .FAIL_OPEN(1'b0)) dut0 (
    .clk           (clk),
    .reset         (reset),
    .bus           (b0),
    .pass_count    (pass0),
    .drop_count    (drop0),
    .timeout_count (to0)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          xfer_cnt = 0;
  bit          toggle_en = 1'b0;
  bit          out0_seen = 1'b0;
  logic [71:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // out_rdy driver: constant 1 or the repeating 1,0,0,1 stall pattern.
  initial begin
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    b.out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) begin
        b.out_rdy = pat[k % 4];
        k++;
      end else begin
        b.out_rdy = 1'b1;
      end
    end
  end

  // Egress monitor, sampled on the falling edge.
  initial begin
    bit          hold_vld;
    logic [71:0] hold_w;
    logic [71:0] e;
    hold_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_vld = 1'b0;
      end else begin
        if (b0.out_wr) out0_seen = 1'b1;
        if (b.out_wr) begin
          if (hold_vld) begin
            chk("stall_data", b.out_data, hold_w[63:0]);
            chk("stall_ctrl", 64'(b.out_ctrl), 64'(hold_w[71:64]));
          end
          if (b.out_rdy) begin
            if (exp_q.size() == 0) begin
              chk("extra_word", 64'(b.out_wr), 64'd0);
            end else begin
              e = exp_q.pop_front();
              chk("out_data", b.out_data, e[63:0]);
              chk("out_ctrl", 64'(b.out_ctrl), 64'(e[71:64]));
            end
            xfer_cnt++;
            hold_vld = 1'b0;
          end else begin
            hold_vld = 1'b1;
            hold_w   = {b.out_ctrl, b.out_data};
          end
        end else begin
          if (hold_vld) chk("stall_wr_drop", 64'(b.out_wr), 64'd1);
          hold_vld = 1'b0;
        end
      end
    end
  end

  task automatic put_word(input logic [63:0] d, input logic [7:0] c, input bit push);
    int guard;
    guard = 0;
    b.in_data = d;
    b.in_ctrl = c;
    b.in_wr   = 1'b1;
    if (push) exp_q.push_back({c, d});
    @(negedge clk);
    while (!b.in_rdy && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) chk("in_rdy_wait", 64'(b.in_rdy), 64'd1);
    @(posedge clk);
    #1;
    b.in_wr = 1'b0;
  endtask

  // Packet: n_hdr header words (ctrl!=0), n_pay payload words, one end word.
  task automatic send_pkt(input int n_hdr, input int n_pay, input logic [15:0] tag, input bit push);
    int idx;
    idx = 0;
    for (int i = 0; i < n_hdr; i++) begin
      put_word({tag, 16'(idx), $urandom}, 8'(8'h40 + i), push);
      idx++;
    end
    for (int i = 0; i < n_pay; i++) begin
      put_word({tag, 16'(idx), $urandom}, 8'h00, push);
      idx++;
    end
    put_word({tag, 16'(idx), $urandom}, 8'h80, push);
  endtask

  // Called at posedge+1; pulses the verdict for one cycle.
  task automatic verdict(input bit m);
    b.verdict_valid = 1'b1;
    b.verdict_match = m;
    @(posedge clk);
    #1;
    b.verdict_valid = 1'b0;
    b.verdict_match = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || !b.in_rdy || b.out_wr) && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk(tag, 64'({exp_q.size() == 0, b.in_rdy, b.out_wr}), 64'b110);
  endtask

  initial begin
    int g;
    int base;
    reset           = 1'b1;
    b.in_data       = '0;
    b.in_ctrl       = '0;
    b.in_wr         = 1'b0;
    b.verdict_valid = 1'b0;
    b.verdict_match = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy", 64'(b.in_rdy), 64'd0);
    chk("rst_out_wr", 64'(b.out_wr), 64'd0);
    chk("rst_out_data", b.out_data, 64'd0);
    chk("rst_out_ctrl", 64'(b.out_ctrl), 64'd0);
    chk("rst_counts", {pass1, drop1 | to1}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_rdy", 64'(b.in_rdy), 64'd1);

    // Stray ctrl=0 word in IDLE is discarded; verdict in IDLE ignored
    put_word(64'hDEAD_0000_0000_0001, 8'h00, 1'b0);
    verdict(1'b1);

    // Clean packet, verdict 0 two cycles after the end word
    send_pkt(2, 4, 16'hC1C1, 1'b1);
    @(posedge clk);
    #1;
    verdict(1'b0);
    chk("fwd_lat_entry", 64'(b.out_wr), 64'd0);
    @(posedge clk);
    #1;
    chk("fwd_lat_first", 64'(b.out_wr), 64'd1);
    wait_drain("drain_clean");
    chk("clean_pass", 64'(pass1), 64'd1);
    chk("clean_drop", 64'(drop1), 64'd0);

    // Matching packet is dropped
    send_pkt(2, 4, 16'hD2D2, 1'b0);
    @(posedge clk);
    #1;
    verdict(1'b1);
    chk("drop_in_rdy_low", 64'(b.in_rdy), 64'd0);
    @(posedge clk);
    #1;
    chk("drop_in_rdy_back", 64'(b.in_rdy), 64'd1);
    chk("drop_count", 64'(drop1), 64'd1);
    chk("drop_pass", 64'(pass1), 64'd1);

    // Output stalls 1,0,0,1,...; early verdict latched during STORE
    toggle_en = 1'b1;
    fork
      send_pkt(2, 4, 16'hE3E3, 1'b1);
      begin
        repeat (4) @(posedge clk);
        #1;
        verdict(1'b0);
      end
    join
    wait_drain("drain_stall");
    toggle_en = 1'b0;
    chk("stall_pass", 64'(pass1), 64'd2);

    // No verdict: timeout on both instances
    out0_seen = 1'b0;
    send_pkt(2, 4, 16'hF4F4, 1'b1);
    repeat (63) @(posedge clk);
    #1;
    chk("to_before", 64'(to1), 64'd0);
    @(posedge clk);
    #1;
    chk("to_open_count", 64'(to1), 64'd1);
    chk("to_closed_count", 64'(to0), 64'd1);
    @(posedge clk);
    #1;
    chk("to_closed_drop", 64'(drop0), 64'd2);
    wait_drain("drain_timeout");
    chk("to_open_pass", 64'(pass1), 64'd3);
    chk("to_closed_pass", 64'(pass0), 64'd2);
    chk("to_closed_no_out", 64'(out0_seen), 64'd0);

    // Oversize 300-word packet is dropped, next packet forwarded intact
    send_pkt(2, 297, 16'h0B0B, 1'b0);
    @(posedge clk);
    #1;
    verdict(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("oversize_drop", 64'(drop1), 64'd2);
    chk("oversize_pass", 64'(pass1), 64'd3);
    send_pkt(2, 4, 16'h5A5A, 1'b1);
    @(posedge clk);
    #1;
    verdict(1'b0);
    wait_drain("drain_after_oversize");
    chk("after_oversize_pass", 64'(pass1), 64'd4);

    // Reset during forwarding, after the third word
    base = xfer_cnt;
    send_pkt(2, 4, 16'h7E7E, 1'b1);
    @(posedge clk);
    #1;
    verdict(1'b0);
    g = 0;
    while (xfer_cnt < base + 3 && g < 200) begin
      @(posedge clk);
      g++;
    end
    chk("reach_word3", 64'(xfer_cnt - base), 64'd3);
    #1;
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("midrst_out_wr", 64'(b.out_wr), 64'd0);
    chk("midrst_counts", {pass1 | drop1 | to1, pass0 | drop0 | to0}, 64'd0);
    chk("midrst_in_rdy", 64'(b.in_rdy), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_pkt(3, 2, 16'h8181, 1'b1);
    @(posedge clk);
    #1;
    verdict(1'b0);
    wait_drain("drain_after_reset");
    chk("after_reset_pass", 64'(pass1), 64'd1);
    chk("after_reset_drop", 64'(drop1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
